psg_bus_if: RTL and testbench



---
 rtl/psg_pkg.sv | 23 ++
 rtl/psg_bus_if_kbd_matrix.sv | 32 +++
 rtl/psg_bus_if.sv | 82 ++++++++
 tb/tb_psg_bus_if.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared definitions for the AY-3-8912 bus interface:
// bus function codes, register indices and data masks.
package psg_pkg;

  localparam logic [1:0] FN_INACTIVE = 2'b00;
  localparam logic [1:0] FN_READ     = 2'b01;
  localparam logic [1:0] FN_WRITE    = 2'b10;
  localparam logic [1:0] FN_LATCH    = 2'b11;

  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_PORTA     = 4'd14;
  localparam logic [3:0] R_PORTB     = 4'd15;

  // Implemented bits per register, index 15 first.
  localparam logic [15:0][7:0] REG_MASK = {
    8'hff, 8'hff, 8'h0f, 8'hff,
    8'hff, 8'h1f, 8'h1f, 8'h1f,
    8'hff, 8'h1f, 8'h0f, 8'hff,
    8'h0f, 8'hff, 8'h0f, 8'hff
  };

endpackage

// File: rtl/psg_bus_if_kbd_matrix.sv
// Keyboard matrix row storage, active-low key state.
// Host loads rows; PSG port A reads one row combinationally.
module kbd_matrix #(
  parameter int KBD_ROWS = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_i,
  input  logic [3:0] wr_row_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] rd_row_i,
  output logic [7:0] rd_data_o
);

  logic [7:0] rows [KBD_ROWS];

  // Host row writes; out-of-range rows are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < KBD_ROWS; i++) rows[i] <= 8'hff;
    end else if (wr_i && (32'(wr_row_i) < KBD_ROWS)) begin
      rows[wr_row_i] <= wr_data_i;
    end
  end

  // Unimplemented rows read as no keys pressed.
  always_comb begin
    rd_data_o = 8'hff;
    if (32'(rd_row_i) < KBD_ROWS) rd_data_o = rows[rd_row_i];
  end

endmodule

// File: rtl/psg_bus_if.sv
// AY-3-8912 bus protocol and register file behind the CPC PPI,
// with keyboard matrix read through port A (R14).
module psg_bus_if
  import psg_pkg::*;
#(
  parameter int KBD_ROWS = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       bdir_i,
  input  logic       bc1_i,
  input  logic [7:0] da_i,
  output logic [7:0] da_o,
  input  logic [3:0] kbd_row_i,
  input  logic       kbd_wr_i,
  input  logic [3:0] kbd_wr_row_i,
  input  logic [7:0] kbd_wr_data_i,
  input  logic [3:0] snd_addr_i,
  output logic [7:0] snd_data_o,
  output logic       env_restart_o
);

  logic [1:0] fn;
  logic [1:0] prev_fn;
  logic [3:0] addr;
  logic       valid;
  logic [7:0] regs [16];
  logic [7:0] kbd_data;
  logic [7:0] rd_val;
  logic       commit;

  assign fn = {bdir_i, bc1_i};
  assign commit = (fn == FN_WRITE) && (prev_fn != FN_WRITE) && valid;

  kbd_matrix #(
    .KBD_ROWS(KBD_ROWS)
  ) u_kbd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_i     (kbd_wr_i),
    .wr_row_i (kbd_wr_row_i),
    .wr_data_i(kbd_wr_data_i),
    .rd_row_i (kbd_row_i),
    .rd_data_o(kbd_data)
  );

  // Value presented for a bus READ of the latched register.
  always_comb begin
    rd_val = regs[addr];
    if (!valid) begin
      rd_val = 8'hff;
    end else if (addr == R_PORTB) begin
      rd_val = 8'hff;
    end else if (addr == R_PORTA && !regs[R_MIXER][6]) begin
      rd_val = kbd_data;
    end
  end

  // Bus sequencing, register file and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_fn       <= FN_INACTIVE;
      addr          <= 4'd0;
      valid         <= 1'b1;
      da_o          <= 8'hff;
      snd_data_o    <= 8'h00;
      env_restart_o <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      prev_fn       <= fn;
      snd_data_o    <= regs[snd_addr_i];
      env_restart_o <= commit && (addr == R_ENV_SHAPE);
      da_o          <= (fn == FN_READ) ? rd_val : 8'hff;
      if (fn == FN_LATCH) begin
        addr  <= da_i[3:0];
        valid <= (da_i[7:4] == 4'd0);
      end
      if (commit) regs[addr] <= da_i & REG_MASK[addr];
    end
  end

endmodule

// File: tb/tb_psg_bus_if.sv
// Directed bench for psg_bus_if: bus protocol, masks,
// envelope strobe, keyboard read and reset behaviour.
module tb_psg_bus_if;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       bdir_i;
  logic       bc1_i;
  logic [7:0] da_i;
  logic [7:0] da_o;
  logic [3:0] kbd_row_i;
  logic       kbd_wr_i;
  logic [3:0] kbd_wr_row_i;
  logic [7:0] kbd_wr_data_i;
  logic [3:0] snd_addr_i;
  logic [7:0] snd_data_o;
  logic       env_restart_o;

  int errors = 0;
  int checks = 0;

  psg_bus_if dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bdir_i       (bdir_i),
    .bc1_i        (bc1_i),
    .da_i         (da_i),
    .da_o         (da_o),
    .kbd_row_i    (kbd_row_i),
    .kbd_wr_i     (kbd_wr_i),
    .kbd_wr_row_i (kbd_wr_row_i),
    .kbd_wr_data_i(kbd_wr_data_i),
    .snd_addr_i   (snd_addr_i),
    .snd_data_o   (snd_data_o),
    .env_restart_o(env_restart_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] f, input logic [7:0] d);
    {bdir_i, bc1_i} = f;
    da_i = d;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    bus(2'b11, a); tick();
    bus(2'b10, d); tick();
    bus(2'b00, 8'h00); tick();
  endtask

  initial begin
    reset_i = 1'b1;
    bus(2'b00, 8'h00);
    kbd_row_i = 4'd0;
    kbd_wr_i = 1'b0;
    kbd_wr_row_i = 4'd0;
    kbd_wr_data_i = 8'hff;
    snd_addr_i = 4'd0;
    tick(2);
    chk("rst_da", da_o, 8'hff);
    chk("rst_snd", snd_data_o, 8'h00);
    chk("rst_env", {7'd0, env_restart_o}, 8'h00);
    reset_i = 1'b0;
    tick();

    // READ of R0 after reset
    bus(2'b01, 8'h00);
    chk("rd0_pre", da_o, 8'hff);
    tick();
    chk("rd0", da_o, 8'h00);
    chk("snd0", snd_data_o, 8'h00);
    bus(2'b00, 8'h00); tick();
    chk("rd_idle", da_o, 8'hff);

    // R1 masked, single commit over held WRITE
    bus(2'b11, 8'h01); tick();
    bus(2'b10, 8'hab); tick();
    da_i = 8'h00; tick(4);
    bus(2'b00, 8'h00); tick();
    snd_addr_i = 4'd1; tick();
    chk("r1_snd", snd_data_o, 8'h0b);
    bus(2'b01, 8'h00); tick();
    chk("r1_rd", da_o, 8'h0b);
    bus(2'b00, 8'h00); tick();

    // R13 commits pulse env_restart once per WRITE entry
    bus(2'b11, 8'h0d); tick();
    bus(2'b10, 8'hff); tick();
    chk("env1_hi", {7'd0, env_restart_o}, 8'h01);
    tick();
    chk("env1_lo", {7'd0, env_restart_o}, 8'h00);
    bus(2'b11, 8'h0d); tick();
    chk("env_latch", {7'd0, env_restart_o}, 8'h00);
    bus(2'b10, 8'hff); tick();
    chk("env2_hi", {7'd0, env_restart_o}, 8'h01);
    tick();
    chk("env2_lo", {7'd0, env_restart_o}, 8'h00);
    bus(2'b00, 8'h00);
    snd_addr_i = 4'd13; tick(2);
    chk("r13_snd", snd_data_o, 8'h0f);

    // Keyboard matrix through R14
    kbd_wr_i = 1'b1; kbd_wr_row_i = 4'd4; kbd_wr_data_i = 8'hfb;
    tick();
    kbd_wr_i = 1'b0;
    wr_reg(8'h07, 8'h00);
    bus(2'b11, 8'h0e); tick();
    kbd_row_i = 4'd4;
    bus(2'b01, 8'h00); tick();
    chk("kbd_r4", da_o, 8'hfb);
    kbd_row_i = 4'd12; tick();
    chk("kbd_r12", da_o, 8'hff);
    kbd_row_i = 4'd4; tick();
    chk("kbd_r4b", da_o, 8'hfb);
    kbd_wr_i = 1'b1; kbd_wr_data_i = 8'h00; tick();
    kbd_wr_i = 1'b0;
    chk("kbd_wr_old", da_o, 8'hfb);
    tick();
    chk("kbd_wr_new", da_o, 8'h00);
    bus(2'b00, 8'h00); tick();
    wr_reg(8'h0e, 8'h5a);
    wr_reg(8'h07, 8'h40);
    bus(2'b11, 8'h0e); tick();
    bus(2'b01, 8'h00); tick();
    chk("r14_out", da_o, 8'h5a);
    bus(2'b00, 8'h00); tick();

    // Invalid address: WRITE dropped, READ gives ff
    bus(2'b11, 8'h17); tick();
    bus(2'b10, 8'h55); tick();
    bus(2'b00, 8'h00);
    snd_addr_i = 4'd7; tick(2);
    chk("inv_r7", snd_data_o, 8'h40);
    bus(2'b01, 8'h00); tick();
    chk("inv_rd", da_o, 8'hff);
    bus(2'b11, 8'h0f); tick();
    bus(2'b01, 8'h00); tick();
    chk("r15_rd", da_o, 8'hff);
    bus(2'b00, 8'h00); tick();

    // Reset during WRITE, then WRITE held across release
    wr_reg(8'h02, 8'h33);
    snd_addr_i = 4'd2; tick();
    chk("r2_set", snd_data_o, 8'h33);
    bus(2'b11, 8'h02); tick();
    bus(2'b10, 8'h99); tick();
    reset_i = 1'b1;
    bus(2'b10, 8'h77); tick();
    chk("mid_rst_da", da_o, 8'hff);
    chk("mid_rst_snd", snd_data_o, 8'h00);
    reset_i = 1'b0; tick();
    da_i = 8'h11; tick(3);
    bus(2'b00, 8'h00);
    snd_addr_i = 4'd0; tick(2);
    chk("rel_r0", snd_data_o, 8'h77);
    snd_addr_i = 4'd2; tick();
    chk("rel_r2", snd_data_o, 8'h00);
    bus(2'b11, 8'h0e); tick();
    kbd_row_i = 4'd4;
    bus(2'b01, 8'h00); tick();
    chk("rel_kbd", da_o, 8'hff);
    bus(2'b00, 8'h00); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
